// File: rtl/key_sel_toggle.sv
// Push-button front end for the 2:1 selector: synchronises and debounces an active-low key,
// emits press/release pulses and flips the select level on every clean press.
module key_sel_toggle #(
  parameter int unsigned          CNT_W   = 20,
  parameter logic [CNT_W-1:0]     CNT_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_level,
  output logic sel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             key_flag_q, key_flag_d;
  logic             key_release_q, key_release_d;
  logic             key_level_q, key_level_d;
  logic             sel_q, sel_d;
  logic             key_s;

  assign key_s = sync2_q;

  // Synchroniser idles at 1 so a reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_d defaults to zero, so every state change and every stable state clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (!key_s) state_d = PRESS_FILT;
      end
      PRESS_FILT: begin
        if (key_s)                  state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = DOWN;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      DOWN: begin
        if (key_s) state_d = REL_FILT;
      end
      REL_FILT: begin
        if (!key_s)                 state_d = DOWN;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_flag_d    = (state_q == PRESS_FILT) && (state_d == DOWN);
    key_release_d = (state_q == REL_FILT) && (state_d == IDLE);
    key_level_d   = (state_d == DOWN) || (state_d == REL_FILT);
    sel_d         = sel_q ^ key_flag_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_flag_q    <= 1'b0;
      key_release_q <= 1'b0;
      key_level_q   <= 1'b0;
      sel_q         <= 1'b0;
    end else begin
      key_flag_q    <= key_flag_d;
      key_release_q <= key_release_d;
      key_level_q   <= key_level_d;
      sel_q         <= sel_d;
    end
  end

  assign key_flag    = key_flag_q;
  assign key_release = key_release_q;
  assign key_level   = key_level_q;
  assign sel         = sel_q;

endmodule

// File: tb/tb_key_sel_toggle.sv
// Bench for key_sel_toggle: a run-length debounce model checked every cycle,
// plus literal latency / pulse-count expectations for each directed case.
module tb_key_sel_toggle;

  localparam int CM = 10;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_flag, key_release, key_level, sel;

  key_sel_toggle #(.CNT_W(20), .CNT_MAX(20'd10)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_flag   (key_flag),
    .key_release(key_release),
    .key_level  (key_level),
    .sel        (sel)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int flag_cnt = 0;
  int rel_cnt = 0;
  int flag_edge = -1;
  int rel_edge = -1;

  // Model: the debounced level flips once the synchronised key has disagreed
  // with it for CM+1 consecutive samples; any agreeing sample restarts the run.
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_ks;
  bit m_lvl = 1'b0, m_flag = 1'b0, m_rel = 1'b0, m_sel = 1'b0;
  int m_run = 0;

  always @(posedge sys_clk) edge_n++;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_run = 0;
      m_flag = 1'b0; m_rel = 1'b0; m_sel = 1'b0;
    end else begin
      m_ks = m_s2;
      m_s2 = m_s1;
      m_s1 = key_in;
      m_flag = 1'b0;
      m_rel  = 1'b0;
      if ((!m_ks) != m_lvl) begin
        m_run++;
        if (m_run == CM + 1) begin
          m_lvl = !m_lvl;
          m_run = 0;
          if (m_lvl) begin
            m_flag = 1'b1;
            m_sel  = !m_sel;
          end else begin
            m_rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (edge_n >= 1) begin
      chk("key_flag", key_flag, m_flag);
      chk("key_release", key_release, m_rel);
      chk("key_level", key_level, m_lvl);
      chk("sel", sel, m_sel);
      chk("pulse_overlap", key_flag & key_release, 1'b0);
      if (key_flag === 1'b1) begin flag_cnt++; flag_edge = edge_n; end
      if (key_release === 1'b1) begin rel_cnt++; rel_edge = edge_n; end
    end
  end

  // Drive v for n rising edges; returns just after a falling edge.
  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    sys_rst_n = 1'b0;
    repeat (n) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  int e0, fc, rc;

  initial begin
    repeat (3) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    hold(1'b1, 50);
    chk_int("t1_flags", flag_cnt, 0);
    chk_int("t1_releases", rel_cnt, 0);
    chk_int("t1_sel", int'(sel), 0);
    $display("case1 idle: flags=%0d releases=%0d sel=%b", flag_cnt, rel_cnt, sel);

    e0 = edge_n + 1;
    hold(1'b0, 40);
    chk_int("t2_flag_latency", flag_edge - e0, 12);
    chk_int("t2_flags", flag_cnt, 1);
    chk_int("t2_sel", int'(sel), 1);
    chk_int("t2_level", int'(key_level), 1);
    $display("case2 press: latency=%0d sel=%b level=%b", flag_edge - e0, sel, key_level);

    e0 = edge_n + 1;
    hold(1'b1, 40);
    chk_int("t3_rel_latency", rel_edge - e0, 12);
    chk_int("t3_releases", rel_cnt, 1);
    chk_int("t3_sel", int'(sel), 1);
    chk_int("t3_level", int'(key_level), 0);
    $display("case3 release: latency=%0d sel=%b level=%b", rel_edge - e0, sel, key_level);

    fc = flag_cnt; rc = rel_cnt;
    hold(1'b0, 4); hold(1'b1, 3); hold(1'b0, 6); hold(1'b1, 20);
    chk_int("t4_flags", flag_cnt - fc, 0);
    chk_int("t4_releases", rel_cnt - rc, 0);
    chk_int("t4_sel", int'(sel), 1);
    $display("case4 bounce: new_flags=%0d sel=%b", flag_cnt - fc, sel);

    pulse_reset(2);
    hold(1'b1, 5);
    chk_int("t5_sel_after_reset", int'(sel), 0);
    fc = flag_cnt;
    hold(1'b0, 5); hold(1'b1, 2);
    e0 = edge_n + 1;
    hold(1'b0, 30);
    chk_int("t5_flag_latency", flag_edge - e0, 12);
    chk_int("t5_flags", flag_cnt - fc, 1);
    chk_int("t5_sel_first", int'(sel), 1);
    hold(1'b1, 30); hold(1'b0, 30); hold(1'b1, 30);
    chk_int("t5_flags_total", flag_cnt - fc, 2);
    chk_int("t5_sel_second", int'(sel), 0);
    $display("case5 bounce+press: latency=%0d flags=%0d sel=%b", flag_edge - e0, flag_cnt - fc, sel);

    fc = flag_cnt;
    hold(1'b0, 10);
    sys_rst_n = 1'b0;
    #1;
    chk_int("t6_rst_flag", int'(key_flag), 0);
    chk_int("t6_rst_level", int'(key_level), 0);
    chk_int("t6_rst_sel", int'(sel), 0);
    repeat (3) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    chk_int("t6_no_flag_before", flag_cnt - fc, 0);
    e0 = edge_n + 1;
    hold(1'b0, 30);
    chk_int("t6_flag_latency", flag_edge - e0, 12);
    chk_int("t6_flags", flag_cnt - fc, 1);
    chk_int("t6_sel", int'(sel), 1);
    hold(1'b1, 30);
    $display("case6 reset mid-filter: latency=%0d flags=%0d sel=%b", flag_edge - e0, flag_cnt - fc, sel);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
